halt_run_monitor: RTL
=====================

Name: halt_run_monitor

Overview:
- Synthesizable multi-core run-control and halt-check engine for the parallel CPU build.
- Per core, it pulses the core reset and counts cycles to HALT. It then checks that the PC holds while halted, re-resets the core, and checks that HALT clears.
- It aggregates pass/fail counts so that on-board regression runs need no simulator.
- It sits beside the NCORES CPU instances and drives their reset inputs; its status feeds LEDR/HEX.

Parameters:
- NCORES, 4, number of monitored cores/channels.
- PC_W, 16, PC width per core.
- CYC_W, 18, cycle counter width; must satisfy 2^CYC_W > MAX_CYCLES.
- MAX_CYCLES, 200000, RUN cycles allowed before timeout.
- RST_CYC, 5, cycles core_rst_n is held low per reset pulse.
- HOLD_CYC, 6, cycles the PC must stay stable after HALT.
- CLR_CYC, 2, cycles after second reset release by which HALT must be 0.
- CNT_W, 8, width of pass/fail counters.

Ports:
- CLOCK_50 in 1: sole clock; all logic on rising edge.
- rst_n in 1: asynchronous, active-low reset (board KEY[1]).
- start in 1: one-cycle pulse that launches a run on all enabled channels.
- chan_en in NCORES: channel enables, sampled on the start cycle.
- halt in NCORES: per-core HALT indicator.
- pc in NCORES*PC_W: per-core PC, with core i at [i*PC_W +: PC_W].
- core_rst_n out NCORES: registered active-low reset to each core.
- status out NCORES*3: per-channel code at [i*3 +: 3].
- cycles out NCORES*CYC_W: per-channel captured halt cycle count.
- busy out 1: high while any channel is in a non-terminal active state.
- all_done out 1: high when a run has completed and no channel is busy.
- pass_cnt out CNT_W: cumulative passes.
- fail_cnt out CNT_W: cumulative fails.

Behaviour:
- Reset (rst_n=0, async) puts:
  - all channels in IDLE, core_rst_n all 1;
  - status 0, cycles 0, busy 0, all_done 0, pass_cnt/fail_cnt 0.
- Reset mid-run aborts everything immediately; no counts are updated.
- Status codes: 0 IDLE, 1 BUSY, 2 PASS, 3 FAIL_TIMEOUT, 4 FAIL_PCMOVE, 5 FAIL_NOCLEAR; 6 and 7 are unused.
- start is accepted only when busy=0; start while busy is ignored.
- On accept, each enabled channel enters RST1 and clears cycles. Disabled channels go to IDLE with status 0 and are excluded from counts.
- Per-channel FSM:
  - IDLE / terminal: wait for accepted start.
  - RST1: core_rst_n=0 for exactly RST_CYC cycles, starting the cycle after start. Then RUN.
  - RUN: core_rst_n=1. The counter increments every RUN cycle, with the first RUN cycle counting 1.
    - If halt=1, capture cycles=count (including that cycle), latch pc0=pc, go to HOLD.
    - Else if count==MAX_CYCLES, go to FAIL_TIMEOUT with cycles=MAX_CYCLES.
    - Halt has priority over timeout on the same cycle.
  - HOLD: for HOLD_CYC cycles, compare pc to pc0.
    - Any mismatch goes to FAIL_PCMOVE immediately.
    - halt dropping during HOLD is not checked.
    - After HOLD_CYC clean cycles, go to RST2.
  - RST2: core_rst_n=0 for RST_CYC cycles, then CLRCHK.
  - CLRCHK: core_rst_n=1; wait CLR_CYC cycles. On the last cycle, halt=0 goes to PASS, else FAIL_NOCLEAR.
- cycles holds its value until the next accepted start or reset.
- Counters:
  - pass_cnt/fail_cnt increment on each channel's entry into a terminal state.
  - Simultaneous completions in one cycle add the full count, e.g. +3.
  - Counters saturate at 2^CNT_W-1.
- Status latency: status goes to 1 the cycle after start. Terminal codes appear on the cycle after the deciding sample.
- all_done: set the cycle after the last active channel reaches terminal; cleared on accepted start.
  - start with chan_en=0 gives all_done=1 the next cycle, with no counts changed.

Test Plan:
- 1 channel, core model halts at RUN cycle 37 with PC fixed at 0x0012, clears on reset -> core_rst_n low 5 cycles twice, cycles=37, status=2, pass_cnt=1, all_done=1.
- Core never halts, MAX_CYCLES overridden to 100 -> status=3, cycles=100, fail_cnt=1, core_rst_n stays 1 after RUN.
- Core halts at cycle 10, PC changes 0x0020->0x0021 on HOLD cycle 3 -> status=4 exactly one cycle after the mismatch sample, cycles=10.
- Core's halt ignores reset, stuck at 1 -> status=5 after CLRCHK, fail_cnt=1.
- 4 channels, chan_en=4'b1011, all halting at cycle 50 -> channels 0,1,3 reach PASS on the same cycle; pass_cnt jumps 0->3 in one cycle; channel 2 status=0.
- start pulsed again mid-RUN is ignored; rst_n pulled low mid-HOLD -> all outputs return to reset values asynchronously, and a following start reruns cleanly.

Source files
------------

// File: rtl/halt_run_monitor.sv
// Multi-core run-control monitor: resets each enabled core, times its run to HALT,
// checks the PC holds while halted, re-resets, checks HALT clears, and tallies the outcomes.
module halt_run_monitor #(
    parameter int NCORES     = 4,
    parameter int PC_W       = 16,
    parameter int CYC_W      = 18,
    parameter int MAX_CYCLES = 200000,
    parameter int RST_CYC    = 5,
    parameter int HOLD_CYC   = 6,
    parameter int CLR_CYC    = 2,
    parameter int CNT_W      = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NCORES-1:0]       chan_en,
    input  logic [NCORES-1:0]       halt,
    input  logic [NCORES*PC_W-1:0]  pc,
    output logic [NCORES-1:0]       core_rst_n,
    output logic [NCORES*3-1:0]     status,
    output logic [NCORES*CYC_W-1:0] cycles,
    output logic                    busy,
    output logic                    all_done,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt
);

    localparam int TMR_MAX = (RST_CYC > HOLD_CYC)
                             ? ((RST_CYC > CLR_CYC) ? RST_CYC : CLR_CYC)
                             : ((HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int INC_W = $clog2(NCORES + 1);
    localparam int SUM_W = CNT_W + INC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_RUN, S_HOLD, S_RST2, S_CLRCHK,
        S_PASS, S_FAIL_TO, S_FAIL_PC, S_FAIL_NC
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == S_RST1) || (s == S_RUN) || (s == S_HOLD) ||
               (s == S_RST2) || (s == S_CLRCHK);
    endfunction

    function automatic logic is_fail(input state_t s);
        return (s == S_FAIL_TO) || (s == S_FAIL_PC) || (s == S_FAIL_NC);
    endfunction

    logic              start_acc;
    logic [NCORES-1:0] active_q_vec;
    logic [NCORES-1:0] active_d_vec;
    logic [NCORES-1:0] pass_hit;
    logic [NCORES-1:0] fail_hit;

    assign busy      = |active_q_vec;
    assign start_acc = start & ~busy;

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [TMR_W-1:0] tmr_q, tmr_d;
            logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
            logic [CYC_W-1:0] cyc_q, cyc_d;
            logic [PC_W-1:0]  pc0_q, pc0_d, pc_i;
            logic             rstn_q, rstn_d;
            logic [2:0]       code;

            assign pc_i    = pc[gi*PC_W +: PC_W];
            assign cnt_inc = cnt_q + CYC_W'(1);

            always_comb begin
                state_d = state_q;
                tmr_d   = tmr_q;
                cnt_d   = cnt_q;
                cyc_d   = cyc_q;
                pc0_d   = pc0_q;
                case (state_q)
                    S_RST1: begin
                        if (tmr_q == TMR_W'(RST_CYC - 1)) begin
                            state_d = S_RUN;
                            tmr_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    S_RUN: begin
                        // The current cycle is included in the count, so halt here reports cnt_inc.
                        cnt_d = cnt_inc;
                        if (halt[gi]) begin
                            state_d = S_HOLD;
                            cyc_d   = cnt_inc;
                            pc0_d   = pc_i;
                            tmr_d   = '0;
                        end else if (cnt_inc == CYC_W'(MAX_CYCLES)) begin
                            state_d = S_FAIL_TO;
                            cyc_d   = CYC_W'(MAX_CYCLES);
                        end
                    end
                    S_HOLD: begin
                        if (pc_i != pc0_q) begin
                            state_d = S_FAIL_PC;
                        end else if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
                            state_d = S_RST2;
                            tmr_d   = '0;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    S_RST2: begin
                        if (tmr_q == TMR_W'(RST_CYC - 1)) begin
                            state_d = S_CLRCHK;
                            tmr_d   = '0;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    S_CLRCHK: begin
                        if (tmr_q == TMR_W'(CLR_CYC - 1)) begin
                            state_d = halt[gi] ? S_FAIL_NC : S_PASS;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    default: ;
                endcase
                // start_acc only fires with no channel active, so this never cuts a run short.
                if (start_acc) begin
                    state_d = chan_en[gi] ? S_RST1 : S_IDLE;
                    tmr_d   = '0;
                    cnt_d   = '0;
                    cyc_d   = '0;
                end
                rstn_d = !((state_d == S_RST1) || (state_d == S_RST2));
            end

            always_comb begin
                code = 3'd0;
                case (state_q)
                    S_RST1, S_RUN, S_HOLD, S_RST2, S_CLRCHK: code = 3'd1;
                    S_PASS:    code = 3'd2;
                    S_FAIL_TO: code = 3'd3;
                    S_FAIL_PC: code = 3'd4;
                    S_FAIL_NC: code = 3'd5;
                    default:   code = 3'd0;
                endcase
            end

            always_ff @(posedge CLOCK_50 or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    tmr_q   <= '0;
                    cnt_q   <= '0;
                    cyc_q   <= '0;
                    pc0_q   <= '0;
                    rstn_q  <= 1'b1;
                end else begin
                    state_q <= state_d;
                    tmr_q   <= tmr_d;
                    cnt_q   <= cnt_d;
                    cyc_q   <= cyc_d;
                    pc0_q   <= pc0_d;
                    rstn_q  <= rstn_d;
                end
            end

            assign active_q_vec[gi]           = is_active(state_q);
            assign active_d_vec[gi]           = is_active(state_d);
            assign pass_hit[gi]               = is_active(state_q) && (state_d == S_PASS);
            assign fail_hit[gi]               = is_active(state_q) && is_fail(state_d);
            assign core_rst_n[gi]             = rstn_q;
            assign status[gi*3 +: 3]          = code;
            assign cycles[gi*CYC_W +: CYC_W]  = cyc_q;
        end
    endgenerate

    logic [INC_W-1:0] pass_inc, fail_inc;
    logic [SUM_W-1:0] pass_sum, fail_sum;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic             run_q, run_d, all_done_q, all_done_d;

    always_comb begin
        pass_inc = '0;
        fail_inc = '0;
        for (int i = 0; i < NCORES; i++) begin
            pass_inc = pass_inc + INC_W'(pass_hit[i]);
            fail_inc = fail_inc + INC_W'(fail_hit[i]);
        end
        pass_sum   = SUM_W'(pass_cnt_q) + SUM_W'(pass_inc);
        fail_sum   = SUM_W'(fail_cnt_q) + SUM_W'(fail_inc);
        pass_cnt_d = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
        fail_cnt_d = (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];
        // all_done follows the next-state view so it lines up with the final terminal code.
        run_d      = run_q | start_acc;
        all_done_d = run_d & ~(|active_d_vec);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            run_q      <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            run_q      <= run_d;
            all_done_q <= all_done_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign all_done = all_done_q;

endmodule
